// File: rtl/btb_update_ctrl_pkg.sv
// Shared constants and types for the BTB update controller: default geometry,
// update entry width and the controller FSM state encoding.
package btb_update_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_INDEX_WIDTH = 6;
  localparam int DEF_INDEX_LSB   = 2;
  localparam int DEF_FIFO_DEPTH  = 4;

  localparam int BTB_INDEX_WIDTH = DEF_INDEX_WIDTH;
  localparam int BTB_SIZE        = 1 << BTB_INDEX_WIDTH;
  localparam int BTB_INDEX_SEL   = DEF_INDEX_LSB;
  localparam int BTB_PC_SEL      = DEF_INDEX_LSB + DEF_INDEX_WIDTH;

  // Update entry layout: {is_jump, pc, target}
  localparam int BTB_ENTRY_WIDTH = 1 + 2 * DEF_ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_t;

  function automatic int entry_width(input int addr_width);
    return 1 + 2 * addr_width;
  endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Request, flush and BTB write-port bundle of the BTB update controller.
// Handshake: a request transfers on a cycle where valid && ready are both 1.
interface btb_update_ctrl_if #(
  parameter int ADDR_WIDTH = btb_update_ctrl_pkg::DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = btb_update_ctrl_pkg::DEF_FIFO_DEPTH
);
  logic                    id_valid;
  logic                    id_ready;
  logic                    id_is_jump;
  logic [ADDR_WIDTH-1:0]   id_pc;
  logic [ADDR_WIDTH-1:0]   id_target;
  logic                    cm_valid;
  logic                    cm_ready;
  logic                    cm_is_jump;
  logic [ADDR_WIDTH-1:0]   cm_pc;
  logic [ADDR_WIDTH-1:0]   cm_target;
  logic                    flush_req;
  logic                    flush_busy;
  logic                    flush_done;
  logic                    btb_write_en;
  logic                    btb_valid;
  logic                    btb_is_jump;
  logic [ADDR_WIDTH-1:0]   btb_inst_pc;
  logic [ADDR_WIDTH-1:0]   btb_target;
  btb_update_ctrl_pkg::ctrl_state_t state;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (
    output id_valid, id_is_jump, id_pc, id_target,
    output cm_valid, cm_is_jump, cm_pc, cm_target, flush_req,
    input  id_ready, cm_ready, flush_busy, flush_done,
    input  btb_write_en, btb_valid, btb_is_jump, btb_inst_pc, btb_target,
    input  state, fifo_count
  );

  modport slave (
    input  id_valid, id_is_jump, id_pc, id_target,
    input  cm_valid, cm_is_jump, cm_pc, cm_target, flush_req,
    output id_ready, cm_ready, flush_busy, flush_done,
    output btb_write_en, btb_valid, btb_is_jump, btb_inst_pc, btb_target,
    output state, fifo_count
  );
endinterface

// File: rtl/btb_update_fifo.sv
// Synchronous FIFO for speculative ID updates. Clear empties it in one edge;
// push is ignored when full and pop when empty.
module btb_update_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Sole BTB writer: commit updates beat queued ID updates, one registered write
// per cycle, and flush_req sequences an invalidate of every line in index order.
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int INDEX_LSB   = DEF_INDEX_LSB,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  btb_update_ctrl_if.slave bus
);
  localparam int ENTRY_W = entry_width(ADDR_WIDTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  ctrl_state_t            state;
  ctrl_state_t            state_next;
  logic [INDEX_WIDTH-1:0] flush_cnt;
  logic                   flush_last;
  logic                   inval_step;
  logic                   cm_accept;
  logic                   id_accept;
  logic                   fifo_pop;
  logic                   fifo_clear;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [ENTRY_W-1:0]     fifo_head;
  logic [ADDR_WIDTH-1:0]  inval_pc;

  // flush_cnt leads the displayed line by one, so wrapping back to 0 while in
  // FLUSH means the last line is on the write port this cycle.
  assign flush_last = (state == ST_FLUSH) && (flush_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (bus.flush_req) state_next = ST_FLUSH;
      ST_FLUSH: if (flush_last)    state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_comb begin
    bus.cm_ready   = (state == ST_RUN) && !bus.flush_req;
    bus.id_ready   = bus.cm_ready && !fifo_full;
    bus.flush_busy = (state == ST_FLUSH);
    cm_accept      = bus.cm_valid && bus.cm_ready;
    id_accept      = bus.id_valid && bus.id_ready;
    fifo_pop       = bus.cm_ready && !cm_accept && !fifo_empty;
    fifo_clear     = (state == ST_RUN) && bus.flush_req;
    inval_step     = fifo_clear || ((state == ST_FLUSH) && !flush_last);
  end

  always_comb begin
    inval_pc = '0;
    inval_pc[INDEX_LSB +: INDEX_WIDTH] = flush_cnt;
  end

  btb_update_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (fifo_clear),
    .push      (id_accept),
    .pop       (fifo_pop),
    .push_data ({bus.id_is_jump, bus.id_pc, bus.id_target}),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Write-port registers; fields hold their last value when write_en drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.btb_write_en <= 1'b0;
      bus.btb_valid    <= 1'b0;
      bus.btb_is_jump  <= 1'b0;
      bus.btb_inst_pc  <= '0;
      bus.btb_target   <= '0;
      bus.flush_done   <= 1'b0;
      flush_cnt        <= '0;
    end else begin
      bus.flush_done <= flush_last;
      if (inval_step) begin
        bus.btb_write_en <= 1'b1;
        bus.btb_valid    <= 1'b0;
        bus.btb_is_jump  <= 1'b0;
        bus.btb_inst_pc  <= inval_pc;
        bus.btb_target   <= '0;
        flush_cnt        <= flush_cnt + 1'b1;
      end else if (cm_accept) begin
        bus.btb_write_en <= 1'b1;
        bus.btb_valid    <= 1'b1;
        bus.btb_is_jump  <= bus.cm_is_jump;
        bus.btb_inst_pc  <= bus.cm_pc;
        bus.btb_target   <= bus.cm_target;
      end else if (fifo_pop) begin
        bus.btb_write_en <= 1'b1;
        bus.btb_valid    <= 1'b1;
        {bus.btb_is_jump, bus.btb_inst_pc, bus.btb_target} <= fifo_head;
      end else begin
        bus.btb_write_en <= 1'b0;
      end
    end
  end

  assign bus.state      = state;
  assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: commit/ID arbitration, FIFO back-pressure,
// full-table invalidate, reset abort and ignored re-flush.
module tb_btb_update_ctrl;
  import btb_update_ctrl_pkg::*;

  localparam int W = 65;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [W-1:0] exp_q[$];

  btb_update_ctrl_if bus ();

  btb_update_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    chk({tag, "_en"}, 96'(bus.btb_write_en), 96'(1));
    chk({tag, "_valid"}, 96'(bus.btb_valid), 96'(1));
    chk({tag, "_data"}, 96'({bus.btb_is_jump, bus.btb_inst_pc, bus.btb_target}), 96'(e));
  endtask

  task automatic check_inval(input string tag, input int idx);
    chk({tag, "_en"}, 96'(bus.btb_write_en), 96'(1));
    chk({tag, "_fields"}, 96'({bus.btb_valid, bus.btb_is_jump, bus.btb_target}), 96'(0));
    chk({tag, "_pc"}, 96'(bus.btb_inst_pc), 96'(32'(idx * 4)));
    chk({tag, "_busy"}, 96'(bus.flush_busy), 96'(1));
  endtask

  initial begin
    int inv;
    int dones;
    int bad;
    rst = 1'b1;
    bus.id_valid = 0; bus.id_is_jump = 0; bus.id_pc = '0; bus.id_target = '0;
    bus.cm_valid = 0; bus.cm_is_jump = 0; bus.cm_pc = '0; bus.cm_target = '0;
    bus.flush_req = 0;
    tick(); tick();
    chk("rst_outputs", 96'({bus.btb_write_en, bus.btb_valid, bus.btb_is_jump,
        bus.btb_inst_pc, bus.btb_target}), 96'(0));
    chk("rst_flags", 96'({bus.flush_busy, bus.flush_done}), 96'(0));
    chk("rst_state", 96'(bus.state), 96'(ST_RUN));
    chk("rst_count", 96'(bus.fifo_count), 96'(0));
    rst = 1'b0;

    // 1: commit write appears one cycle after accept
    bus.cm_valid = 1; bus.cm_is_jump = 0; bus.cm_pc = 32'h1000; bus.cm_target = 32'h2000;
    #1; chk("t1_cm_ready", 96'(bus.cm_ready), 96'(1));
    exp_q.push_back({1'b0, 32'h1000, 32'h2000});
    tick(); bus.cm_valid = 0;
    check_write("t1_cm");
    tick();
    chk("t1_idle_en", 96'(bus.btb_write_en), 96'(0));
    chk("t1_hold_pc", 96'(bus.btb_inst_pc), 96'(32'h1000));

    // 2a: five back-to-back ID updates, first write two cycles after accept
    for (int k = 0; k < 5; k++) begin
      bus.id_valid = 1; bus.id_is_jump = k[0];
      bus.id_pc = 32'(32'h100 + k * 4); bus.id_target = 32'(32'h4000 + k * 16);
      exp_q.push_back({k[0], 32'(32'h100 + k * 4), 32'(32'h4000 + k * 16)});
      #1; chk("t2a_id_ready", 96'(bus.id_ready), 96'(1));
      tick();
      if (k == 0) chk("t2a_no_write_t1", 96'(bus.btb_write_en), 96'(0));
      else        check_write("t2a_id");
    end
    bus.id_valid = 0;
    tick(); check_write("t2a_id_last");
    tick(); chk("t2a_idle", 96'(bus.btb_write_en), 96'(0));

    // 2b: commit held four cycles fills the FIFO; fifth ID stalls one cycle
    for (int j = 0; j < 4; j++) begin
      bus.cm_valid = 1; bus.cm_is_jump = 1;
      bus.cm_pc = 32'(32'h3000 + j * 4); bus.cm_target = 32'(32'h7000 + j * 4);
      bus.id_valid = 1; bus.id_is_jump = 0;
      bus.id_pc = 32'(32'h500 + j * 4); bus.id_target = 32'(32'h8000 + j * 4);
      #1; chk("t2b_id_ready", 96'(bus.id_ready), 96'(1));
      tick();
      chk("t2b_cm_data", 96'({bus.btb_valid, bus.btb_is_jump, bus.btb_inst_pc}),
          96'({2'b11, 32'(32'h3000 + j * 4)}));
    end
    bus.cm_valid = 0;
    bus.id_pc = 32'h510; bus.id_target = 32'h8010;
    #1;
    chk("t2b_full_count", 96'(bus.fifo_count), 96'(4));
    chk("t2b_full_stall", 96'(bus.id_ready), 96'(0));
    for (int j = 0; j < 5; j++) exp_q.push_back({1'b0, 32'(32'h500 + j * 4), 32'(32'h8000 + j * 4)});
    tick(); check_write("t2b_id0");
    chk("t2b_resume", 96'(bus.id_ready), 96'(1));
    tick(); bus.id_valid = 0; check_write("t2b_id1");
    tick(); check_write("t2b_id2");
    tick(); check_write("t2b_id3");
    tick(); check_write("t2b_id4");
    tick(); chk("t2b_idle", 96'(bus.btb_write_en), 96'(0));

    // 3: simultaneous ID and commit with empty FIFO
    bus.cm_valid = 1; bus.cm_is_jump = 0; bus.cm_pc = 32'h700; bus.cm_target = 32'h7700;
    bus.id_valid = 1; bus.id_is_jump = 1; bus.id_pc = 32'h600; bus.id_target = 32'h6600;
    exp_q.push_back({1'b0, 32'h700, 32'h7700});
    exp_q.push_back({1'b1, 32'h600, 32'h6600});
    #1; chk("t3_readies", 96'({bus.cm_ready, bus.id_ready}), 96'(2'b11));
    tick(); bus.cm_valid = 0; bus.id_valid = 0;
    check_write("t3_cm_first");
    tick(); check_write("t3_id_second");
    tick(); chk("t3_idle", 96'(bus.btb_write_en), 96'(0));

    // 4: flush with three queued ID updates
    for (int j = 0; j < 3; j++) begin
      bus.cm_valid = 1; bus.cm_pc = 32'(32'h800 + j * 4); bus.cm_target = 32'h1;
      bus.id_valid = 1; bus.id_pc = 32'(32'h900 + j * 4); bus.id_target = 32'h2;
      tick();
    end
    chk("t4_queued", 96'(bus.fifo_count), 96'(3));
    bus.flush_req = 1;
    #1; chk("t4_req_readies", 96'({bus.cm_ready, bus.id_ready}), 96'(0));
    tick(); bus.flush_req = 0;
    chk("t4_cleared", 96'(bus.fifo_count), 96'(0));
    for (int i = 0; i < 64; i++) begin
      check_inval("t4_inv", i);
      chk("t4_no_done", 96'(bus.flush_done), 96'(0));
      if (i == 63) begin bus.cm_valid = 0; bus.id_valid = 0; end
      #1; chk("t4_readies", 96'({bus.cm_ready, bus.id_ready}), 96'(0));
      tick();
    end
    chk("t4_done", 96'({bus.flush_done, bus.flush_busy, bus.btb_write_en}), 96'(3'b100));
    chk("t4_hold_pc", 96'(bus.btb_inst_pc), 96'(32'h0FC));
    chk("t4_state", 96'(bus.state), 96'(ST_RUN));
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.btb_write_en !== 1'b0 || bus.flush_done !== 1'b0) bad++;
    end
    chk("t4_dropped_entries", 96'(bad), 96'(0));

    // 5: reset aborts a flush at index 10
    bus.flush_req = 1; #1; tick(); bus.flush_req = 0;
    for (int i = 0; i <= 10; i++) begin
      check_inval("t5_inv", i);
      if (i == 10) rst = 1;
      tick();
    end
    rst = 0;
    chk("t5_outputs", 96'({bus.btb_write_en, bus.btb_valid, bus.btb_is_jump,
        bus.btb_inst_pc, bus.btb_target}), 96'(0));
    chk("t5_flags", 96'({bus.flush_busy, bus.flush_done}), 96'(0));
    chk("t5_state", 96'(bus.state), 96'(ST_RUN));
    bad = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (bus.flush_done !== 1'b0 || bus.btb_write_en !== 1'b0) bad++;
    end
    chk("t5_no_done", 96'(bad), 96'(0));

    // 6: flush_req during FLUSH is ignored
    bus.flush_req = 1; #1; tick(); bus.flush_req = 0;
    inv = 0; dones = 0; bad = 0;
    for (int c = 0; c < 80; c++) begin
      if (bus.btb_write_en === 1'b1 && bus.btb_valid === 1'b0) begin
        if (bus.btb_inst_pc !== 32'(inv * 4)) bad++;
        inv++;
      end
      if (bus.flush_done === 1'b1) dones++;
      bus.flush_req = (c == 5);
      #1; tick();
    end
    bus.flush_req = 0;
    chk("t6_inval_count", 96'(inv), 96'(64));
    chk("t6_done_count", 96'(dones), 96'(1));
    chk("t6_order", 96'(bad), 96'(0));
    chk("t6_state", 96'(bus.state), 96'(ST_RUN));
    chk("scoreboard_empty", 96'(exp_q.size()), 96'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
